// File: rtl/pattern_scan_ctrl.sv
// Memory-port sequencer for the 5-bit pattern search: loads the pattern, scans the
// message byte by byte, and writes the in-byte, any-hit and full-string counts back.
module pattern_scan_ctrl #(
    parameter int BASE_ADDR = 0,
    parameter int NBYTES    = 32,
    parameter int PAT_ADDR  = 32,
    parameter int OUT_ADDR  = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] dm_addr,
    input  logic [7:0] dm_rd_data,
    output logic       dm_wr_en,
    output logic [7:0] dm_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SCAN  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [7:0] L_BASE = 8'(BASE_ADDR);
    localparam logic [7:0] L_PAT  = 8'(PAT_ADDR);
    localparam logic [7:0] L_OUT  = 8'(OUT_ADDR);
    localparam logic [5:0] L_LAST = 6'(NBYTES - 1);

    state_t     r_state;
    logic [4:0] r_pat;
    logic [5:0] r_idx;
    logic [3:0] r_prev_lo;
    logic [7:0] r_ctb;
    logic [7:0] r_cto;
    logic [7:0] r_cts;
    logic [1:0] r_widx;
    logic       r_done;

    logic [2:0] w_inb;
    logic [3:0] w_cross;
    logic [3:0] w_cts_inc;

    // Windows lying entirely inside one byte: b[7:3], b[6:2], b[5:1], b[4:0].
    function automatic logic [2:0] count_inbyte(input logic [7:0] b, input logic [4:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i +: 5] == p) n = n + 3'd1;
            else                n = n;
        end
        return n;
    endfunction

    // Windows whose last bit lands in the current byte, spanning back into the previous one.
    function automatic logic [3:0] count_cross(input logic [11:0] w, input logic [4:0] p);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (w[i +: 5] == p) n = n + 4'd1;
            else                n = n;
        end
        return n;
    endfunction

    // Per-byte hit counts from the byte currently on the read bus.
    always_comb begin
        w_inb   = count_inbyte(dm_rd_data, r_pat);
        w_cross = count_cross({r_prev_lo, dm_rd_data}, r_pat);
        if (r_idx == 6'd0) w_cts_inc = {1'b0, w_inb};
        else               w_cts_inc = w_cross;
    end

    // Sequencer state, counters and the sticky done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pat     <= 5'd0;
            r_idx     <= 6'd0;
            r_prev_lo <= 4'd0;
            r_ctb     <= 8'd0;
            r_cto     <= 8'd0;
            r_cts     <= 8'd0;
            r_widx    <= 2'd0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ctb   <= 8'd0;
                        r_cto   <= 8'd0;
                        r_cts   <= 8'd0;
                        r_idx   <= 6'd0;
                        r_widx  <= 2'd0;
                        r_done  <= 1'b0;
                        r_state <= S_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    r_pat   <= dm_rd_data[7:3];
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    r_ctb     <= r_ctb + 8'(w_inb);
                    r_cto     <= r_cto + 8'(w_inb != 3'd0);
                    r_cts     <= r_cts + 8'(w_cts_inc);
                    r_prev_lo <= dm_rd_data[3:0];
                    r_idx     <= r_idx + 6'd1;
                    if (r_idx == L_LAST) r_state <= S_WRITE;
                    else                 r_state <= S_SCAN;
                end
                S_WRITE: begin
                    if (r_widx == 2'd2) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_widx  <= r_widx + 2'd1;
                        r_state <= S_WRITE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory port drive, decoded from state and index.
    always_comb begin
        dm_addr    = 8'd0;
        dm_wr_en   = 1'b0;
        dm_wr_data = 8'd0;
        case (r_state)
            S_IDLE:  dm_addr = 8'd0;
            S_LOAD:  dm_addr = L_PAT;
            S_SCAN:  dm_addr = L_BASE + {2'b00, r_idx};
            S_WRITE: begin
                dm_wr_en = 1'b1;
                dm_addr  = L_OUT + {6'd0, r_widx};
                case (r_widx)
                    2'd0:    dm_wr_data = r_ctb;
                    2'd1:    dm_wr_data = r_cto;
                    2'd2:    dm_wr_data = r_cts;
                    default: dm_wr_data = 8'd0;
                endcase
            end
            default: dm_addr = 8'd0;
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed and random runs against a bit-string reference model.
module tb_pattern_scan_ctrl;

    localparam int NB = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;

    logic [7:0] img      [0:255];
    logic [7:0] log_addr [0:1023];
    logic [7:0] log_data [0:1023];
    int         wr_count = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .dm_addr    (dm_addr),
        .dm_rd_data (dm_rd_data),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data)
    );

    assign dm_rd_data = img[dm_addr];

    // Every write the DUT makes is logged in order.
    always @(posedge clk) begin
        if (dm_wr_en) begin
            log_addr[wr_count[9:0]] <= dm_addr;
            log_data[wr_count[9:0]] <= dm_wr_data;
            wr_count <= wr_count + 1;
        end
    end

    // Treat message as one 8*NB-bit string, MSB of byte 0 first, and slide a 5-bit window over it.
    function automatic void ref_counts(output int eb, output int eo, output int es);
        int bits [0:255];
        int hitb [0:31];
        int p;
        int v;
        p  = int'(img[32][7:3]);
        eb = 0; eo = 0; es = 0;
        for (int i = 0; i < 8 * NB; i++) bits[i] = int'(img[i / 8][7 - (i % 8)]);
        for (int k = 0; k < NB; k++) hitb[k] = 0;
        for (int j = 0; j <= 8 * NB - 5; j++) begin
            v = 0;
            for (int t = 0; t < 5; t++) v = v * 2 + bits[j + t];
            if (v == p) begin
                es++;
                if ((j % 8) <= 3) begin
                    eb++;
                    hitb[j / 8]++;
                end
            end
        end
        for (int k = 0; k < NB; k++) if (hitb[k] > 0) eo++;
    endfunction

    task automatic fill(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] rest,
                        input logic [7:0] pb);
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        img[0] = b0;
        img[1] = b1;
        for (int k = 2; k < NB; k++) img[k] = rest;
        img[32] = pb;
    endtask

    task automatic fill_random();
        logic [7:0] pb;
        pb = 8'($urandom);
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if ($urandom_range(0, 2) == 0) img[k] = {pb[7:3], 3'($urandom)};
            else                          img[k] = 8'($urandom);
        end
        img[32] = pb;
    endtask

    // Issue a start pulse and follow the run; optionally pulse start again or assert reset mid-run.
    task automatic run(input int pulse_at, input int reset_at, output int cyc, output bit both_high);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        both_high = 1'b0;
        while (!done && cyc < 200) begin
            if (cyc == pulse_at)          start = 1'b1;
            else if (cyc == pulse_at + 1) start = 1'b0;
            if (cyc == reset_at) begin
                reset = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cyc++;
            if (busy && done) both_high = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dm_wr_en !== 1'b0 || dm_addr !== 8'd0 || dm_wr_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b done=%b wr_en=%b addr=%0d wdata=%0d, required all 0",
                     busy, done, dm_wr_en, dm_addr, dm_wr_data);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [7:0] b0 [0:3] = '{8'h00, 8'hFF, 8'h55, 8'h03};
        logic [7:0] b1 [0:3] = '{8'h00, 8'hFF, 8'h55, 8'h80};
        logic [7:0] br [0:3] = '{8'h00, 8'hFF, 8'h55, 8'hFF};
        logic [7:0] pb [0:3] = '{8'h00, 8'h00, 8'hA8, 8'hE0};
        int ex [0:3][0:2] = '{'{128, 32, 252}, '{0, 0, 0}, '{64, 32, 126}, '{0, 0, 1}};
        int  cyc;
        int  wb;
        bit  bh;
        for (int c = 0; c < 4; c++) begin
            fill(b0[c], b1[c], br[c], pb[c]);
            wb = wr_count;
            run(-1, -1, cyc, bh);
            n_tests++;
            if (cyc !== NB + 4 || bh !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_timing case %0d: done after %0d edges both_high=%b, required %0d and 0",
                         c, cyc, bh, NB + 4);
            end
            n_tests++;
            if (wr_count !== wb + 3) begin
                n_fail++;
                $display("FAIL directed_wrcount case %0d: %0d writes, required 3", c, wr_count - wb);
            end
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (log_addr[wb + k] !== 8'(33 + k) || log_data[wb + k] !== 8'(ex[c][k])) begin
                    n_fail++;
                    $display("FAIL directed_result case %0d word %0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                             c, k, log_addr[wb + k], log_data[wb + k], 33 + k, ex[c][k]);
                end
            end
            if (c == 0) begin
                repeat (3) @(posedge clk);
                #1;
                n_tests++;
                if (done !== 1'b1 || busy !== 1'b0 || wr_count !== wb + 3) begin
                    n_fail++;
                    $display("FAIL done_hold: done=%b busy=%b writes=%0d, required 1 0 3",
                             done, busy, wr_count - wb);
                end
            end
        end
    endtask

    task automatic test_busy_and_reset();
        int cyc;
        int wb;
        int eb, eo, es;
        bit bh;
        fill_random();
        ref_counts(eb, eo, es);
        wb = wr_count;
        run(5, -1, cyc, bh);
        n_tests++;
        if (cyc !== NB + 4 || wr_count !== wb + 3 || bh !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ignored_timing: edges=%0d writes=%0d both_high=%b, required %0d 3 0",
                     cyc, wr_count - wb, bh, NB + 4);
        end
        n_tests++;
        if (log_data[wb] !== 8'(eb) || log_data[wb + 1] !== 8'(eo) || log_data[wb + 2] !== 8'(es)) begin
            n_fail++;
            $display("FAIL start_ignored_result: got %0d %0d %0d, required %0d %0d %0d",
                     log_data[wb], log_data[wb + 1], log_data[wb + 2], eb, eo, es);
        end
        wb = wr_count;
        run(-1, 12, cyc, bh);
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dm_wr_en !== 1'b0 || dm_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b wr_en=%b addr=%0d, required 0 0 0 0",
                     busy, done, dm_wr_en, dm_addr);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (wr_count !== wb || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_writes: writes=%0d busy=%b done=%b, required 0 0 0",
                     wr_count - wb, busy, done);
        end
        fill_random();
        ref_counts(eb, eo, es);
        wb = wr_count;
        run(-1, -1, cyc, bh);
        n_tests++;
        if (cyc !== NB + 4 || wr_count !== wb + 3 || log_data[wb] !== 8'(eb) ||
            log_data[wb + 1] !== 8'(eo) || log_data[wb + 2] !== 8'(es)) begin
            n_fail++;
            $display("FAIL restart_result: edges=%0d got %0d %0d %0d, required %0d edges %0d %0d %0d",
                     cyc, log_data[wb], log_data[wb + 1], log_data[wb + 2], NB + 4, eb, eo, es);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int wb;
        int eb, eo, es;
        fill_random();
        ref_counts(eb, eo, es);
        wb = wr_count;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== NB + 4) begin
            n_fail++;
            $display("FAIL b2b_first_timing: %0d edges, required %0d", cyc, NB + 4);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
        end
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== NB + 4 || wr_count !== wb + 6) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d writes=%0d, required %0d 6", cyc, wr_count - wb, NB + 4);
        end
        for (int r = 0; r < 2; r++) begin
            n_tests++;
            if (log_data[wb + 3 * r] !== 8'(eb) || log_data[wb + 3 * r + 1] !== 8'(eo) ||
                log_data[wb + 3 * r + 2] !== 8'(es)) begin
                n_fail++;
                $display("FAIL b2b_result run %0d: got %0d %0d %0d, required %0d %0d %0d", r,
                         log_data[wb + 3 * r], log_data[wb + 3 * r + 1], log_data[wb + 3 * r + 2], eb, eo, es);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int wb;
        int eb, eo, es;
        bit bh;
        for (int it = 0; it < 20; it++) begin
            fill_random();
            ref_counts(eb, eo, es);
            wb = wr_count;
            run(-1, -1, cyc, bh);
            n_tests++;
            if (cyc !== NB + 4 || bh !== 1'b0 || wr_count !== wb + 3) begin
                n_fail++;
                $display("FAIL random_timing iter %0d: edges=%0d both_high=%b writes=%0d, required %0d 0 3",
                         it, cyc, bh, wr_count - wb, NB + 4);
            end
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (log_addr[wb + k] !== 8'(33 + k) ||
                    log_data[wb + k] !== 8'((k == 0) ? eb : ((k == 1) ? eo : es))) begin
                    n_fail++;
                    $display("FAIL random_result iter %0d word %0d: addr=%0d data=%0d, required addr=%0d data=%0d",
                             it, k, log_addr[wb + k], log_data[wb + k], 33 + k,
                             (k == 0) ? eb : ((k == 1) ? eo : es));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_and_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
